// File: rtl/energy_acc_ctrl.sv
// Sequential energy accumulator controller: walks rows k=0..DATASPIN-1 and sums the datapath partial energies.
// Optional feature: define ENERGY_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module energy_acc_ctrl #(
    parameter int DATASPIN         = 256,
    parameter int BITJ             = 4,
    parameter int BITH             = 4,
    parameter int SCALING_BIT      = 5,
    parameter int ENERGY_TOTAL_BIT = 16,
    localparam int KW              = (DATASPIN > 1) ? $clog2(DATASPIN) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_valid_i,
    output logic                               start_ready_o,
    input  logic [DATASPIN-1:0]                spin_i,
    input  logic [SCALING_BIT-1:0]             hscaling_i,
    output logic                               weight_req_o,
    output logic [KW-1:0]                      weight_addr_o,
    input  logic                               weight_valid_i,
    input  logic [DATASPIN*BITJ-1:0]           weight_i,
    input  logic [BITH-1:0]                    hbias_i,
    output logic [DATASPIN-1:0]                spin_o,
    output logic [DATASPIN-1:0]                spin_mask_o,
    output logic [DATASPIN*BITJ-1:0]           weight_o,
    output logic [BITH-1:0]                    hbias_o,
    output logic [SCALING_BIT-1:0]             hscaling_o,
    input  logic signed [ENERGY_TOTAL_BIT-1:0] partial_energy_i,
    output logic                               energy_valid_o,
    input  logic                               energy_ready_i,
    output logic signed [ENERGY_TOTAL_BIT-1:0] energy_o,
    output logic                               busy_o
);
    localparam int W = ENERGY_TOTAL_BIT;

    typedef enum logic [1:0] {IDLE, FETCH, ACC, DONE} state_t;

    state_t                   state;
    logic [KW-1:0]            k;
    logic [W-1:0]             acc;
    logic [W-1:0]             acc_next;
    logic [DATASPIN-1:0]      spin_q;
    logic [DATASPIN-1:0]      mask_q;
    logic [SCALING_BIT-1:0]   hscaling_q;
    logic [DATASPIN*BITJ-1:0] weight_q;
    logic [BITH-1:0]          hbias_q;
    logic                     start_ready_q;
    logic                     weight_req_q;
    logic                     energy_valid_q;
    logic                     busy_q;

`ifdef ENERGY_ACC_SAT_EN
    logic [W:0] sum_ext;

    // One extra bit exposes signed overflow; clamp to the nearest representable limit.
    always_comb begin
        sum_ext = {acc[W-1], acc} + {partial_energy_i[W-1], partial_energy_i};
        if (sum_ext[W] != sum_ext[W-1])
            acc_next = sum_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            acc_next = sum_ext[W-1:0];
    end
`else
    always_comb begin
        acc_next = acc + partial_energy_i;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            k              <= '0;
            acc            <= '0;
            spin_q         <= '0;
            mask_q         <= '0;
            hscaling_q     <= '0;
            weight_q       <= '0;
            hbias_q        <= '0;
            start_ready_q  <= 1'b1;
            weight_req_q   <= 1'b0;
            energy_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid_i) begin
                        spin_q        <= spin_i;
                        hscaling_q    <= hscaling_i;
                        acc           <= '0;
                        k             <= '0;
                        mask_q        <= {{(DATASPIN-1){1'b0}}, 1'b1};
                        start_ready_q <= 1'b0;
                        weight_req_q  <= 1'b1;
                        busy_q        <= 1'b1;
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    if (weight_valid_i) begin
                        weight_q     <= weight_i;
                        hbias_q      <= hbias_i;
                        weight_req_q <= 1'b0;
                        state        <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    // Last row goes straight to DONE; the mask is cleared with it.
                    if (k == KW'(DATASPIN - 1)) begin
                        mask_q         <= '0;
                        energy_valid_q <= 1'b1;
                        state          <= DONE;
                    end else begin
                        k            <= k + KW'(1);
                        mask_q       <= mask_q << 1;
                        weight_req_q <= 1'b1;
                        state        <= FETCH;
                    end
                end
                DONE: begin
                    if (energy_ready_i) begin
                        energy_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        start_ready_q  <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready_o  = start_ready_q;
    assign weight_req_o   = weight_req_q;
    assign weight_addr_o  = k;
    assign spin_o         = spin_q;
    assign spin_mask_o    = mask_q;
    assign weight_o       = weight_q;
    assign hbias_o        = hbias_q;
    assign hscaling_o     = hscaling_q;
    assign energy_valid_o = energy_valid_q;
    assign energy_o       = acc;
    assign busy_o         = busy_q;

endmodule

// File: doc/energy_acc_ctrl.md
ENERGY_ACC_CTRL -- requirements
Module: energy_acc_ctrl

Interface
REQ-001 SHALL have parameter DATASPIN, default 256, number of spins per evaluation.
REQ-002 SHALL have parameter BITJ, default 4, signed weight width.
REQ-003 SHALL have parameter BITH, default 4, signed bias width.
REQ-004 SHALL have parameter SCALING_BIT, default 5, signed bias-scaling width.
REQ-005 SHALL have parameter ENERGY_TOTAL_BIT, default 16, signed partial and total energy width.
REQ-006 SHALL have ports, in order:
- clk_i  in  1  sole clock, all state on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_valid_i  in  1  start request.
- start_ready_o  out  1  controller is able to accept a start.
- spin_i  in  DATASPIN  spin vector; captured at start.
- hscaling_i  in  SCALING_BIT  bias scaling; captured at start.
- weight_req_o  out  1  weight-row fetch request.
- weight_addr_o  out  $clog2(DATASPIN)  row index requested.
- weight_valid_i  in  1  row data valid.
- weight_i  in  DATASPIN*BITJ  weight row.
- hbias_i  in  BITH  bias of the row.
- spin_o  out  DATASPIN  spin vector to the datapath.
- spin_mask_o  out  DATASPIN  one-hot mask to the datapath.
- weight_o  out  DATASPIN*BITJ  latched row to the datapath.
- hbias_o  out  BITH  latched bias to the datapath.
- hscaling_o  out  SCALING_BIT  latched scaling to the datapath.
- partial_energy_i  in  ENERGY_TOTAL_BIT  combinational datapath result.
- energy_valid_o  out  1  total energy available.
- energy_ready_i  in  1  consumer accepts the total.
- energy_o  out  ENERGY_TOTAL_BIT  accumulated signed total.
- busy_o  out  1  high in every state except IDLE.

Function
REQ-007 SHALL implement the FSM states IDLE, FETCH, ACC and DONE.
REQ-008 SHALL, in IDLE, drive start_ready_o=1 and, on start_valid_i, register spin_i and hscaling_i, clear the accumulator, clear the index k to 0 and enter FETCH.
REQ-009 SHALL, in FETCH, drive weight_req_o=1 with weight_addr_o=k.
REQ-010 SHALL, in FETCH on weight_valid_i, latch weight_i and hbias_i and enter ACC; without weight_valid_i it SHALL stay in FETCH with the request and address held.
REQ-011 SHALL, in ACC, add partial_energy_i into the accumulator; if k==DATASPIN-1 it SHALL enter DONE, otherwise it SHALL increment k and return to FETCH.
REQ-012 SHALL drive spin_mask_o as one-hot at bit k in FETCH and ACC and as all zeros otherwise; spin_o, weight_o, hbias_o and hscaling_o SHALL come directly from registers.
REQ-013 SHALL give a latency from accepted start to energy_valid_o of 2*DATASPIN+1 cycles when weight_valid_i answers in the same cycle as the request; each stall cycle SHALL add one cycle.
REQ-014 SHALL, in DONE, hold energy_valid_o=1 and energy_o stable until energy_ready_i is high, then enter IDLE on that cycle.
REQ-015 SHALL keep start_ready_o=0 outside IDLE; start_valid_i outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-016 SHALL ignore weight_valid_i outside FETCH.
REQ-017 SHALL perform accumulation as signed, sign-extended arithmetic of ENERGY_TOTAL_BIT width; overflow handling is defined in REQ-021.

Reset
REQ-018 SHALL, while rst_ni=0, force the state to IDLE, k to 0, the accumulator and all data registers to 0, and weight_req_o, energy_valid_o and busy_o to 0.
REQ-019 SHALL abort any evaluation in progress when reset asserts mid-operation, produce no energy_valid_o pulse afterwards, and resume in IDLE with start_ready_o=1 after deassertion.

Configuration
REQ-020 SHALL provide macro ENERGY_ACC_SAT_EN.
REQ-021 SHALL, when ENERGY_ACC_SAT_EN is defined, saturate each accumulation to the signed limits of ENERGY_TOTAL_BIT (max 2^(W-1)-1, min -2^(W-1)); when it is undefined, additions SHALL wrap modulo 2^ENERGY_TOTAL_BIT.

Verification
REQ-022 SHALL cover nominal operation: DATASPIN=4 with a stub where partial_energy_i=5 and weight_valid_i is tied to 1 -> energy_o=20, energy_valid_o rises 9 cycles after start, and masks 0001, 0010, 0100, 1000 appear in order.
REQ-023 SHALL cover fetch stall: DATASPIN=4 with weight_valid_i delayed 3 cycles on row 2 -> weight_addr_o holds 2 for 4 cycles, energy_o=20, and latency is 12 cycles.
REQ-024 SHALL cover overflow: DATASPIN=4, ENERGY_TOTAL_BIT=8 and partial_energy_i=100 -> energy_o=127 with ENERGY_ACC_SAT_EN defined and -112 without it; a test with partial_energy_i=-100 SHALL give -128 with the macro defined.
REQ-025 SHALL cover output back-pressure: energy_ready_i held low for 5 cycles -> energy_valid_o and energy_o stay stable, start_ready_o stays 0, and IDLE is entered one cycle after energy_ready_i rises.
REQ-026 SHALL cover reset mid-operation: rst_ni pulsed low during k=2 -> outputs are zero immediately, and a following start with partial_energy_i=-3 gives -12.
REQ-027 SHALL cover start while busy: start_valid_i asserted during ACC -> no effect on k, and exactly one result is produced.
